// File: rtl/crc_stream_master_pkg.sv
// Shared constants for the CRC stream master: FSM encoding, register offsets.
// Build option: CRC_STREAM_FINAL_XOR_EN applies CRC_XOROUT to the result.
package crc_stream_master_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RES  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [31:0] CTRL_OFS   = 32'h0;
    localparam logic [31:0] DATA_OFS   = 32'h4;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    function automatic logic is_access(input logic [2:0] s);
        return (s == S_INIT) || (s == S_RD) ||
               (s == S_WR)   || (s == S_RES);
    endfunction

endpackage

// File: rtl/crc_stream_master_if.sv
// Request/grant bus between the CRC stream master and the system decoder.
interface crc_stream_master_if;

    logic        bus_req;
    logic        bus_gnt;
    logic        m_valid;
    logic        m_wr_en;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport master (
        output bus_req, m_valid, m_wr_en, m_addr, m_wdata,
        input  bus_gnt, m_rdata
    );

    modport slave (
        input  bus_req, m_valid, m_wr_en, m_addr, m_wdata,
        output bus_gnt, m_rdata
    );

endinterface

// File: rtl/crc_stream_master.sv
// Streams RAM words into an external CRC accelerator and fetches the result.
// Define CRC_STREAM_FINAL_XOR_EN to invert the fetched result.
module crc_stream_master
    import crc_stream_master_pkg::*;
#(
    parameter logic [31:0] CRC_BASE = 32'h0002_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [CNT_W-1:0] word_count,
    crc_stream_master_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [31:0]      crc_result
);

`ifdef CRC_STREAM_FINAL_XOR_EN
    localparam logic [31:0] XOR_MASK = CRC_XOROUT;
`else
    localparam logic [31:0] XOR_MASK = 32'h0;
`endif

    logic [2:0]       r_state;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_idx;
    logic [31:0]      r_data;
    logic [31:0]      r_crc;

    logic             w_acc;
    logic             w_fire;
    logic             w_last;
    logic [CNT_W-1:0] w_idx_nx;

    assign w_acc    = is_access(r_state);
    assign w_fire   = w_acc && bus.bus_gnt;
    assign w_idx_nx = r_idx + 1'b1;
    assign w_last   = (w_idx_nx == r_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_crc   <= CRC_INIT;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_INIT;
                    r_addr  <= src_addr & ~32'h3;
                    r_cnt   <= word_count;
                    r_idx   <= '0;
                end
                S_INIT: if (w_fire) begin
                    r_state <= (r_cnt == '0) ? S_RES : S_RD;
                end
                S_RD: if (w_fire) begin
                    r_data  <= bus.m_rdata;
                    r_state <= S_WR;
                end
                S_WR: if (w_fire) begin
                    r_idx   <= w_idx_nx;
                    r_addr  <= r_addr + 32'd4;
                    r_state <= w_last ? S_RES : S_RD;
                end
                S_RES: if (w_fire) begin
                    r_crc   <= bus.m_rdata ^ XOR_MASK;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus outputs decode straight from state, so they hold while waiting.
    always_comb begin
        bus.m_valid = 1'b0;
        bus.m_wr_en = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        unique case (r_state)
            S_INIT: begin
                bus.m_valid = 1'b1;
                bus.m_wr_en = 1'b1;
                bus.m_addr  = CRC_BASE + CTRL_OFS;
            end
            S_RD: begin
                bus.m_valid = 1'b1;
                bus.m_addr  = r_addr;
            end
            S_WR: begin
                bus.m_valid = 1'b1;
                bus.m_wr_en = 1'b1;
                bus.m_addr  = CRC_BASE + DATA_OFS;
                bus.m_wdata = r_data;
            end
            S_RES: begin
                bus.m_valid = 1'b1;
                bus.m_addr  = CRC_BASE + DATA_OFS;
            end
            default: ;
        endcase
    end

    assign bus.bus_req = w_acc;
    assign busy        = w_acc;
    assign done        = (r_state == S_DONE);
    assign crc_result  = r_crc;

endmodule

// File: tb/tb_crc_stream_master.sv
// Self-checking bench: RAM + CRC accelerator slave, table and random jobs.
module tb_crc_stream_master;

    localparam logic [31:0] BASE = 32'h0002_0000;
    localparam int          CW   = 4;
`ifdef CRC_STREAM_FINAL_XOR_EN
    localparam logic [31:0] XM = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] XM = 32'h0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic          busy;
    logic          done;
    logic [31:0]   crc_result;

    crc_stream_master_if bus_if();

    crc_stream_master #(.CRC_BASE(BASE), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .word_count (word_count),
        .bus        (bus_if),
        .busy       (busy),
        .done       (done),
        .crc_result (crc_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    task automatic chk(string nm, logic [64:0] act, logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(logic [31:0] c, logic [7:0] b);
        c = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // Slave side: RAM, CRC-32 accelerator (empty stream reads back the seed).
    logic [31:0] ram [logic [31:0]];
    logic [31:0] acc_raw = 32'hFFFF_FFFF;
    logic        acc_fed = 1'b0;
    logic [31:0] acc_rd;
    int          gnt_mode = 0;
    logic        rnd_gnt = 1'b1;
    int          stall_cnt = 0;
    logic        is_wrd;
    logic        fire;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t log_q[$];

    assign acc_rd = acc_fed ? ~acc_raw : 32'hFFFF_FFFF;
    assign is_wrd = bus_if.m_valid && bus_if.m_wr_en &&
                    (bus_if.m_addr == BASE + 32'd4);
    assign fire   = bus_if.bus_req && bus_if.bus_gnt && bus_if.m_valid;

    always_comb begin
        bus_if.bus_gnt = 1'b1;
        if (gnt_mode == 1) bus_if.bus_gnt = !(is_wrd && stall_cnt < 3);
        else if (gnt_mode == 2) bus_if.bus_gnt = rnd_gnt;
    end

    always_comb begin
        bus_if.m_rdata = 32'h0;
        if (bus_if.m_valid && !bus_if.m_wr_en) begin
            if (bus_if.m_addr == BASE + 32'd4) bus_if.m_rdata = acc_rd;
            else if (ram.exists(bus_if.m_addr)) bus_if.m_rdata = ram[bus_if.m_addr];
            else bus_if.m_rdata = 32'hDEAD_BEEF;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rnd_gnt <= ($urandom_range(0, 9) < 7);
        if (done) done_cnt <= done_cnt + 1;
        if (is_wrd && !bus_if.bus_gnt) stall_cnt <= stall_cnt + 1;
        else if (fire) stall_cnt <= 0;
        if (fire) begin
            log_q.push_back({bus_if.m_wr_en, bus_if.m_addr,
                             bus_if.m_wr_en ? bus_if.m_wdata : 32'h0});
            if (bus_if.m_wr_en && bus_if.m_addr == BASE) begin
                acc_raw <= 32'hFFFF_FFFF;
                acc_fed <= 1'b0;
            end else if (is_wrd) begin
                acc_raw <= crc_byte(crc_byte(crc_byte(crc_byte(acc_raw,
                           bus_if.m_wdata[7:0]), bus_if.m_wdata[15:8]),
                           bus_if.m_wdata[23:16]), bus_if.m_wdata[31:24]);
                acc_fed <= 1'b1;
            end
        end
    end

    // While a request waits for grant the bus outputs must not move.
    logic [65:0] snap;
    logic        was_wait = 1'b0;
    always @(negedge clk) begin
        if (was_wait) begin
            checks++;
            if ({bus_if.m_valid, bus_if.m_wr_en, bus_if.m_addr, bus_if.m_wdata} !== snap) begin
                errors++;
                $display("FAIL stable: got %h expected %h",
                    {bus_if.m_valid, bus_if.m_wr_en, bus_if.m_addr, bus_if.m_wdata}, snap);
            end
        end
        was_wait = bus_if.m_valid && !bus_if.bus_gnt && rst_n && !abort;
        snap = {bus_if.m_valid, bus_if.m_wr_en, bus_if.m_addr, bus_if.m_wdata};
    end

    task automatic run_job(string nm, logic [31:0] src, int n, int mode,
                           bit zero, bit disturb, bit c_lat, int e_lat,
                           bit c_crc, logic [31:0] e_crc);
        acc_t        exp_q[$];
        logic [31:0] base_a;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] ref_c;
        int          t0;
        int          d0;
        gnt_mode = mode;
        base_a = src & ~32'h3;
        ref_c = 32'hFFFF_FFFF;
        exp_q.push_back({1'b1, BASE, 32'h0});
        for (int i = 0; i < n; i++) begin
            a = base_a + 32'(4 * i);
            w = zero ? 32'h0 : $urandom;
            ram[a] = w;
            exp_q.push_back({1'b0, a, 32'h0});
            exp_q.push_back({1'b1, BASE + 32'd4, w});
            for (int b = 0; b < 4; b++) ref_c = crc_byte(ref_c, w[8*b +: 8]);
        end
        exp_q.push_back({1'b0, BASE + 32'd4, 32'h0});
        ref_c = (n == 0) ? 32'hFFFF_FFFF : ~ref_c;
        ref_c = ref_c ^ XM;
        if (c_crc) chk({nm, "_golden"}, ref_c, e_crc);
        log_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        src_addr = src;
        word_count = CW'(n);
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        src_addr = $urandom;
        word_count = CW'($urandom);
        for (int k = 0; k < 2000 && !done; k++) begin
            start = (disturb && k == 2);
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, done, 1'b1);
        if (c_lat) chk({nm, "_latency"}, cyc - t0, e_lat);
        chk({nm, "_crc"}, crc_result, ref_c);
        chk({nm, "_nacc"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk({nm, "_acc"}, log_q[i], exp_q[i]);
        @(negedge clk);
        chk({nm, "_done_once"}, done_cnt - d0, 1);
        chk({nm, "_idle"}, {busy, done, bus_if.bus_req, bus_if.m_valid,
            bus_if.m_wr_en, bus_if.m_addr, bus_if.m_wdata}, 65'h0);
    endtask

    typedef struct {
        logic [31:0] src;
        int          n;
        int          mode;
        bit          zero;
        bit          c_lat;
        int          e_lat;
        bit          c_crc;
        logic [31:0] e_crc;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] held;
    int          n0;

    initial begin
        tbl[0] = '{32'h0000_0100, 1, 0, 1, 1, 5, 1, 32'h2144_DF1C ^ XM};
        tbl[1] = '{32'h0000_0200, 0, 0, 0, 1, 3, 1, 32'hFFFF_FFFF ^ XM};
        tbl[2] = '{32'h0000_0300, 4, 1, 0, 1, 23, 0, 32'h0};
        tbl[3] = '{32'h0000_0402, 3, 0, 0, 1, 9, 0, 32'h0};
        tbl[4] = '{32'hFFFF_FFF8, 4, 0, 0, 1, 11, 0, 32'h0};
        tbl[5] = '{32'h0000_0500, 5, 2, 0, 0, 0, 0, 32'h0};
        tbl[6] = '{32'h0000_0800, 15, 0, 0, 1, 33, 0, 32'h0};

        repeat (3) @(negedge clk);
        chk("reset_ctl", {busy, done, bus_if.bus_req, bus_if.m_valid}, 4'h0);
        chk("reset_bus", {bus_if.m_wr_en, bus_if.m_addr, bus_if.m_wdata}, 65'h0);
        chk("reset_crc", crc_result, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_job($sformatf("vec%0d", i), tbl[i].src, tbl[i].n, tbl[i].mode,
                    tbl[i].zero, 1'b0, tbl[i].c_lat, tbl[i].e_lat,
                    tbl[i].c_crc, tbl[i].e_crc);

        run_job("disturb", 32'h0000_0900, 3, 0, 1'b0, 1'b1, 1'b1, 9, 1'b0, 32'h0);

        // Abort during the second RD of an N=4 job.
        gnt_mode = 0;
        for (int i = 0; i < 4; i++) ram[32'h600 + 32'(4 * i)] = $urandom;
        held = crc_result;
        n0 = done_cnt;
        start = 1'b1;
        src_addr = 32'h600;
        word_count = 4'd4;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus_if.m_valid && !bus_if.m_wr_en && bus_if.m_addr == 32'h604) break;
            @(negedge clk);
        end
        chk("abort_rd2_seen", bus_if.m_addr, 32'h604);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_req", {bus_if.bus_req, busy, bus_if.m_valid}, 3'b000);
        repeat (10) @(negedge clk);
        chk("abort_nodone", done_cnt, n0);
        chk("abort_crc", crc_result, held);
        run_job("post_abort", 32'h0000_0A00, 2, 0, 1'b0, 1'b0, 1'b1, 7, 1'b0, 32'h0);

        // Reset mid-job.
        for (int i = 0; i < 3; i++) ram[32'h700 + 32'(4 * i)] = $urandom;
        start = 1'b1;
        src_addr = 32'h700;
        word_count = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {bus_if.bus_req, bus_if.m_valid, busy}, 3'b000);
        chk("rst_mid_crc", crc_result, 32'hFFFF_FFFF);
        n0 = log_q.size();
        repeat (3) @(negedge clk);
        chk("rst_mid_noacc", log_q.size(), n0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 12; r++)
            run_job($sformatf("rnd%0d", r), {20'h0, 8'($urandom), 4'($urandom)},
                    $urandom_range(0, 6), $urandom_range(0, 2), 1'b0, 1'b0,
                    1'b0, 0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
